plane_rd_seq: RTL and testbench

// - Reader side of the output plane buffer: once the writer flags a finished R*C plane, walks it in raster order and streams each neuron downstream.
// - Sits between the output neuron buffer (1-cycle read latency) and the next layer or host readback, with valid/ready flow control.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/plane_rd_seq_if.sv | 28 ++
 rtl/plane_rd_fifo.sv | 49 ++++
 rtl/plane_rd_seq.sv | 152 +++++++++++++++
 tb/tb_plane_rd_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN buffer definitions: reader FSM states and default geometry.
// Used by plane_rd_seq and the writer-side plane logic.
package cnn_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_PLANE_SIZE = 784;
  localparam int DEF_NUM_PLANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/plane_rd_seq_if.sv
// Buffer read port and downstream stream of the plane reader.
// master = plane_rd_seq side, slave = buffer/consumer side.
interface plane_rd_seq_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/plane_rd_fifo.sv
// 2-entry fall-through FIFO with occupancy output.
// A push into an empty FIFO is visible on dout_o in the same cycle.
module plane_rd_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rptr_q;
  logic         wptr_q;
  logic [1:0]   cnt_q;
  logic         empty;
  logic         wr;
  logic         rd;

  assign empty = (cnt_q == 2'd0);
  // a word pushed and popped while empty bypasses storage entirely
  assign wr    = push_i & ~(empty & pop_i);
  assign rd    = pop_i & ~empty;

  assign dout_o  = empty ? din_i : mem_q[rptr_q];
  assign valid_o = ~empty | push_i;
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (wr) wptr_q <= ~wptr_q;
      if (rd) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(wr) - 2'(rd);
    end
  end

endmodule

// File: rtl/plane_rd_seq.sv
// Plane reader: streams a finished R*C plane from the output buffer in raster order.
// Build option PLANE_RD_RELU_EN clamps negative output words to zero.
module plane_rd_seq
  import cnn_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PLANE_SIZE = DEF_PLANE_SIZE,
  parameter int NUM_PLANES = DEF_NUM_PLANES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           plane_rdy,
  plane_rd_seq_if.master bus,
  output logic           busy,
  output logic           overrun
);

  localparam int IDX_W = $clog2(PLANE_SIZE);
  localparam int PL_W  = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PLANE_SIZE - 1);
  localparam logic [PL_W-1:0]   PL_LAST  = PL_W'(NUM_PLANES - 1);
  localparam logic [ADDR_W-1:0] PS_A     = ADDR_W'(PLANE_SIZE);

  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [PL_W-1:0]   pl_q, pl_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_last_q, rd_last_d;
  logic              arr_q, arr_last_q;

  logic [DATA_W:0]   f_dout;
  logic              f_valid;
  logic [1:0]        f_cnt;
  logic              pop;
  logic [1:0]        cnt_nxt;
  logic              can_issue;
  logic              last_xfer;
  logic [DATA_W-1:0] head;

  plane_rd_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (arr_q),
    .din_i   ({arr_last_q, bus.rd_data}),
    .pop_i   (pop),
    .dout_o  (f_dout),
    .valid_o (f_valid),
    .count_o (f_cnt)
  );

  assign pop       = f_valid & bus.out_ready;
  assign last_xfer = pop & f_dout[DATA_W];
  // rd_en is registered, so judge the slot against next-cycle occupancy
  assign cnt_nxt   = f_cnt + 2'(arr_q) - 2'(pop);
  assign can_issue = (3'(cnt_nxt) + 3'(rd_en_q)) < 3'd2;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    pl_d      = pl_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_last_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (plane_rdy | pending_q) state_d = READ;
      end
      READ: begin
        if (can_issue) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + ADDR_W'(idx_q);
          rd_last_d = (idx_q == IDX_LAST);
          if (idx_q == IDX_LAST) state_d = DRAIN;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_d = IDLE;
          if (pl_q == PL_LAST) begin
            base_d = '0;
            pl_d   = '0;
          end else begin
            base_d = base_q + PS_A;
            pl_d   = pl_q + PL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // IDLE consumes one request; a second one in the same cycle stays queued
    if (state_q == IDLE) begin
      pending_d = pending_q & plane_rdy;
    end else if (plane_rdy) begin
      if (pending_q) overrun_d = 1'b1;
      else pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      pl_q       <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      arr_q      <= 1'b0;
      arr_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      pl_q       <= pl_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
      arr_q      <= rd_en_q;
      arr_last_q <= rd_last_q;
    end
  end

  assign head = f_valid ? f_dout[DATA_W-1:0] : '0;

`ifdef PLANE_RD_RELU_EN
  assign bus.out_data = head[DATA_W-1] ? '0 : head;
`else
  assign bus.out_data = head;
`endif

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = f_valid;
  assign bus.out_last  = f_valid & f_dout[DATA_W];
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_plane_rd_seq.sv
// Self-checking bench for plane_rd_seq (PLANE_SIZE=16, NUM_PLANES=2).
// Reference: expected stream built per plane from base=(n%NUM_PLANES)*PLANE_SIZE.
module tb_plane_rd_seq;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int PS = 16;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic plane_rdy = 1'b0;
  logic busy;
  logic overrun;
  logic fix_rdy = 1'b1;
  logic rnd_rdy = 1'b0;
  logic rnd_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  int nplane = 0;

  logic [DW-1:0] mem [64];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];

  int   infl = 0;
  int   arrived = 0;
  int   xfer = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pl = 1'b0;
  logic [DW-1:0] pd = '0;

  plane_rd_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  plane_rd_seq #(
    .DATA_W(DW), .ADDR_W(AW), .PLANE_SIZE(PS), .NUM_PLANES(NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .plane_rdy (plane_rdy),
    .bus       (bus),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rnd_rdy ? rnd_bit : fix_rdy;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[5:0]];
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input int addr);
    logic [DW-1:0] w;
    w = mem[addr % 64];
`ifdef PLANE_RD_RELU_EN
    if (w[DW-1]) w = '0;
`endif
    return w;
  endfunction

  task automatic add_plane();
    int base;
    base = (nplane % NP) * PS;
    for (int i = 0; i < PS; i++)
      exp_q.push_back({(i == PS - 1), model_word(base + i)});
    nplane++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    step(1);
    plane_rdy = 1'b1;
    step(1);
    plane_rdy = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      step(1);
      c++;
    end
    chk("got_cnt", got_q.size(), n);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_size"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  // stream monitor: occupancy rule, output stability, transfer capture
  always @(negedge clk) begin
    if (rst) begin
      infl = 0;
      arrived = 0;
      xfer = 0;
      pv = 1'b0;
    end else begin
      if (bus.rd_en)
        chk("rd_occ", 32'((arrived - xfer + infl) < 2), 1);
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, pd);
        chk("hold_last", bus.out_last, pl);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_last, bus.out_data});
        xfer++;
      end
      arrived += infl;
      infl = bus.rd_en ? 1 : 0;
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    step(3);
    chk_reset("rst");
    rst = 1'b0;
    step(2);

    // basic stream, latency and full throughput
    step(1);
    plane_rdy = 1'b1;
    add_plane();
    step(1);
    plane_rdy = 1'b0;
    chk("busy_rise", busy, 1);
    chk("lat1_valid", bus.out_valid, 0);
    step(1);
    chk("lat2_valid", bus.out_valid, 0);
    chk("first_rd_en", bus.rd_en, 1);
    chk("first_rd_addr", bus.rd_addr, 0);
    step(1);
    chk("lat3_valid", bus.out_valid, 1);
    chk("lat3_data", bus.out_data, model_word(0));
    wait_got(PS, PS);
    step(2);
    chk("basic_busy", busy, 0);
    cmp_all("basic");

    // random backpressure on random buffer contents
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    rnd_rdy = 1'b1;
    pulse();
    add_plane();
    wait_got(PS, 400);
    step(3);
    chk("bp_busy", busy, 0);
    cmp_all("bp");

    // back-to-back planes; the second wraps the base via NUM_PLANES
    pulse();
    add_plane();
    wait_got(8, 200);
    pulse();
    add_plane();
    wait_got(2 * PS, 400);
    step(3);
    chk("b2b_busy", busy, 0);
    cmp_all("b2b");
    rnd_rdy = 1'b0;

    // three requests while busy: one queued, one dropped
    chk("ovr_init", overrun, 0);
    pulse();
    add_plane();
    step(2);
    pulse();
    add_plane();
    chk("ovr_pend", overrun, 0);
    pulse();
    chk("ovr_set", overrun, 1);
    wait_got(2 * PS, 300);
    step(20);
    chk("ovr_planes", got_q.size(), 2 * PS);
    chk("ovr_busy", busy, 0);
    chk("ovr_sticky", overrun, 1);
    cmp_all("ovr");

    // reset in the middle of a plane
    pulse();
    wait_got(5, 50);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    step(2);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    nplane = 0;
`ifdef PLANE_RD_RELU_EN
    mem[0] = 16'hFFF0;
    mem[1] = 16'h0010;
`endif
    pulse();
    add_plane();
    c = 0;
    while (!bus.rd_en && c < 10) begin
      step(1);
      c++;
    end
    chk("restart_rd_en", bus.rd_en, 1);
    chk("restart_addr", bus.rd_addr, 0);
    wait_got(PS, 100);
    step(3);
`ifdef PLANE_RD_RELU_EN
    if (got_q.size() >= 2) begin
      chk("relu_neg", got_q[0][DW-1:0], 0);
      chk("relu_pos", got_q[1][DW-1:0], 16'h0010);
    end
`endif
    cmp_all("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
